// File: rtl/boruss_debug_uart_tx_if.sv
// Debug snapshot interface between the CPU debug taps and the UART trace block.
// master: drives trigger and the CPU debug values, observes the serial line/status.
// slave : the UART trace block (boruss_debug_uart_tx).
//   trigger       snapshot request
//   pc            CPU program counter
//   cpu_state     CPU FSM state
//   debug_reg_a-d CPU registers A..D
//   uart_tx       serial line, idles high
//   busy          frame in flight
//   frame_done    one-cycle frame completion pulse
//   drop_count    saturating count of triggers rejected while busy
interface boruss_debug_uart_tx_if;
    logic       trigger;
    logic [7:0] pc;
    logic [2:0] cpu_state;
    logic [7:0] debug_reg_a;
    logic [7:0] debug_reg_b;
    logic [7:0] debug_reg_c;
    logic [7:0] debug_reg_d;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] drop_count;

    modport master (
        output trigger, pc, cpu_state, debug_reg_a, debug_reg_b, debug_reg_c, debug_reg_d,
        input  uart_tx, busy, frame_done, drop_count
    );

    modport slave (
        input  trigger, pc, cpu_state, debug_reg_a, debug_reg_b, debug_reg_c, debug_reg_d,
        output uart_tx, busy, frame_done, drop_count
    );
endinterface

// File: rtl/boruss_debug_uart_tx.sv
// CPU debug trace transmitter: on trigger, snapshots pc/cpu_state/regs a..d and
// streams an 8-byte frame (sync, pc, state, a, b, c, d, xor checksum) as 8N1 UART.
// Ports:
//   clk   board clock, rising edge
//   reset synchronous, active-high
//   dbg   slave side of boruss_debug_uart_tx_if (trigger + debug values in,
//         uart_tx/busy/frame_done/drop_count out, all registered)
module boruss_debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    boruss_debug_uart_tx_if.slave   dbg
);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        drop_q, drop_d;
    logic [7:0][7:0]   snap_q, snap_d;

    logic              baud_end;
    logic [2:0]        bit_next;
    logic [7:0]        state_byte;
    logic [7:0]        checksum;

    assign baud_end   = (baud_q == BAUD_LAST);
    assign bit_next   = bit_q + 3'd1;
    assign state_byte = {5'b0, dbg.cpu_state};
    assign checksum   = dbg.pc ^ state_byte ^ dbg.debug_reg_a ^ dbg.debug_reg_b
                      ^ dbg.debug_reg_c ^ dbg.debug_reg_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state and registered-output logic; tx_d is the line level for the next cycle
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = drop_q;
        snap_d  = snap_q;

        if (busy_q && dbg.trigger && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (dbg.trigger) begin
                    snap_d  = {checksum, dbg.debug_reg_d, dbg.debug_reg_c, dbg.debug_reg_b,
                               dbg.debug_reg_a, state_byte, dbg.pc, SYNC_BYTE};
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = snap_q[byte_q][0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_next;
                        tx_d  = snap_q[byte_q][bit_next];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == 3'd7) begin
                        state_d = IDLE;
                        byte_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg.uart_tx    = tx_q;
    assign dbg.busy       = busy_q;
    assign dbg.frame_done = done_q;
    assign dbg.drop_count = drop_q;
endmodule

// File: tb/tb_boruss_debug_uart_tx.sv
// Self-checking bench for boruss_debug_uart_tx with CLKS_PER_BIT=4.
// Frames are predicted from the captured values by a per-cycle line model.
module tb_boruss_debug_uart_tx;
    localparam int C = 4;
    localparam int F = 80 * C;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic wave [0:1023];
    int   busy_cnt;
    int   done_cnt;
    int   done_at [0:3];

    boruss_debug_uart_tx_if ifc ();

    boruss_debug_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [7:0] p, input logic [2:0] s, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        ifc.pc = p; ifc.cpu_state = s;
        ifc.debug_reg_a = a; ifc.debug_reg_b = b; ifc.debug_reg_c = c; ifc.debug_reg_d = d;
    endtask

    task automatic set_random_inputs();
        set_inputs(8'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.trigger = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Frame bytes as a 64-bit word, byte i at bits [8i+:8]
    function automatic logic [63:0] model_frame(input logic [7:0] p, input logic [2:0] s,
                                                input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
        logic [7:0] by [8];
        logic [63:0] f;
        by[0] = 8'hA5; by[1] = p; by[2] = {5'b0, s};
        by[3] = a; by[4] = b; by[5] = c; by[6] = d;
        by[7] = 8'h00;
        for (int i = 1; i <= 6; i++) by[7] = by[7] ^ by[i];
        for (int i = 0; i < 8; i++) f[8*i +: 8] = by[i];
        return f;
    endfunction

    function automatic logic [63:0] model_from_inputs();
        return model_frame(ifc.pc, ifc.cpu_state, ifc.debug_reg_a, ifc.debug_reg_b,
                           ifc.debug_reg_c, ifc.debug_reg_d);
    endfunction

    // Expected line level in cycle k (1-based) of a frame: 10 bits per byte, C cycles each
    function automatic logic exp_bit(input logic [63:0] f, input int k);
        int idx = (k - 1) / C;
        int by  = idx / 10;
        int pos = idx % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return f[by*8 + pos - 1];
    endfunction

    function automatic int wave_errs(input logic [63:0] f, input int off);
        int n = 0;
        for (int k = 1; k <= F; k++) if (wave[off + k] !== exp_bit(f, k)) n++;
        return n;
    endfunction

    function automatic logic [7:0] decode_byte(input int off, input int i);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = wave[off + (i*10 + 1 + j)*C + C/2];
        return b;
    endfunction

    // Records line level, busy and frame_done for ncyc cycles after the current edge
    task automatic sample_window(input int ncyc);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            wave[k] = ifc.uart_tx;
            if (ifc.busy === 1'b1) busy_cnt++;
            if (ifc.frame_done === 1'b1) begin
                if (done_cnt < 4) done_at[done_cnt] = k;
                done_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        ifc.trigger = 1'b0;
        set_inputs(8'h00, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({ifc.uart_tx, ifc.busy, ifc.frame_done, ifc.drop_count} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: tx/busy/done/drop=%b/%b/%b/%h required 1/0/0/00",
                     ifc.uart_tx, ifc.busy, ifc.frame_done, ifc.drop_count);
        end
        for (int k = 0; k < 50; k++) begin
            tick();
            if ({ifc.uart_tx, ifc.busy, ifc.frame_done, ifc.drop_count} !== {3'b100, 8'h00})
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] lit [8] = '{8'hA5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h04, 8'h08, 8'h1E};
        logic [63:0] f;
        int e;
        do_reset();
        set_inputs(8'h12, 3'd3, 8'h01, 8'h02, 8'h04, 8'h08);
        f = model_from_inputs();
        ifc.trigger = 1'b1;
        fork
            sample_window(F + 10);
            begin tick(); ifc.trigger = 1'b0; end
        join
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (decode_byte(0, i) !== lit[i]) begin
                errors++;
                $display("FAIL single_byte%0d: got %h required %h", i, decode_byte(0, i), lit[i]);
            end
        end
        e = wave_errs(f, 0);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL single_wave: %0d bad cycles, required 0", e); end
        checks++;
        if (busy_cnt !== F) begin
            errors++; $display("FAIL single_busy: busy %0d cycles, required %0d", busy_cnt, F);
        end
        checks++;
        if (done_cnt !== 1 || done_at[0] !== F + 1) begin
            errors++;
            $display("FAIL single_done: %0d pulses first at %0d, required 1 at %0d",
                     done_cnt, done_at[0], F + 1);
        end
    endtask

    task automatic test_coherence();
        logic [63:0] f;
        do_reset();
        set_inputs(8'h12, 3'd3, 8'h01, 8'h02, 8'h04, 8'h08);
        f = model_from_inputs();
        ifc.trigger = 1'b1;
        fork
            sample_window(F + 10);
            begin tick(); ifc.trigger = 1'b0; tick(); ifc.debug_reg_a = 8'hFF; end
        join
        checks++;
        if (decode_byte(0, 3) !== 8'h01) begin
            errors++; $display("FAIL coh_reg_a: got %h required 01", decode_byte(0, 3));
        end
        checks++;
        if (decode_byte(0, 7) !== 8'h1E) begin
            errors++; $display("FAIL coh_checksum: got %h required 1E", decode_byte(0, 7));
        end
        checks++;
        if (wave_errs(f, 0) !== 0) begin
            errors++; $display("FAIL coh_wave: %0d bad cycles, required 0", wave_errs(f, 0));
        end
    endtask

    task automatic test_drops();
        logic [63:0] f;
        int k1, k2, k3;
        int drops = 0;
        do_reset();
        set_random_inputs();
        f = model_from_inputs();
        k1 = int'($urandom_range(5, 100));
        k2 = int'($urandom_range(110, 200));
        k3 = int'($urandom_range(210, 310));
        ifc.trigger = 1'b1;
        fork
            sample_window(F + 10);
            begin
                tick(); ifc.trigger = 1'b0;
                for (int k = 1; k < F; k++) begin
                    ifc.trigger = (k == k1 || k == k2 || k == k3);
                    if (ifc.trigger) drops++;
                    tick();
                end
                ifc.trigger = 1'b0;
            end
        join
        checks++;
        if (ifc.drop_count !== 8'(drops)) begin
            errors++; $display("FAIL drop_three: drop_count %h required %h", ifc.drop_count, 8'(drops));
        end
        checks++;
        if (wave_errs(f, 0) !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL drop_frame: %0d bad cycles %0d done pulses, required 0 and 1",
                     wave_errs(f, 0), done_cnt);
        end
        // Second frame with trigger held high for its first 300 busy cycles
        set_random_inputs();
        f = model_from_inputs();
        ifc.trigger = 1'b1;
        fork
            sample_window(F + 10);
            begin
                tick();
                repeat (300) begin drops++; tick(); end
                ifc.trigger = 1'b0;
            end
        join
        checks++;
        if (ifc.drop_count !== ((drops > 255) ? 8'hFF : 8'(drops))) begin
            errors++; $display("FAIL drop_saturate: drop_count %h required FF", ifc.drop_count);
        end
        checks++;
        if (wave_errs(f, 0) !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL drop_held_frame: %0d bad cycles %0d done pulses, required 0 and 1",
                     wave_errs(f, 0), done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f1, f2;
        do_reset();
        set_random_inputs();
        f1 = model_from_inputs();
        f2 = '0;
        ifc.trigger = 1'b1;
        fork
            sample_window(2*F + 12);
            begin
                tick(); ifc.trigger = 1'b0;
                repeat (F) tick();
                set_random_inputs();
                f2 = model_from_inputs();
                ifc.trigger = 1'b1;
                tick();
                ifc.trigger = 1'b0;
            end
        join
        checks++;
        if (wave_errs(f1, 0) !== 0) begin
            errors++; $display("FAIL b2b_first: %0d bad cycles, required 0", wave_errs(f1, 0));
        end
        checks++;
        if (wave[F + 1] !== 1'b1 || wave[F + 2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: line %b then %b, required 1 then 0", wave[F + 1], wave[F + 2]);
        end
        checks++;
        if (wave_errs(f2, F + 1) !== 0) begin
            errors++; $display("FAIL b2b_second: %0d bad cycles, required 0", wave_errs(f2, F + 1));
        end
        checks++;
        if (done_cnt !== 2 || done_at[0] !== F + 1 || done_at[1] !== 2*F + 2) begin
            errors++;
            $display("FAIL b2b_done: %0d pulses at %0d,%0d required 2 at %0d,%0d",
                     done_cnt, done_at[0], done_at[1], F + 1, 2*F + 2);
        end
        checks++;
        if (ifc.drop_count !== 8'h00) begin
            errors++; $display("FAIL b2b_drops: drop_count %h required 00", ifc.drop_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] f;
        int bad = 0;
        do_reset();
        set_random_inputs();
        ifc.trigger = 1'b1;
        tick();
        ifc.trigger = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            ifc.trigger = (k == 50);
            tick();
        end
        ifc.trigger = 1'b0;
        checks++;
        if (ifc.drop_count !== 8'h01 || ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: drop_count %h busy %b required 01 and 1",
                     ifc.drop_count, ifc.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({ifc.uart_tx, ifc.busy, ifc.frame_done, ifc.drop_count} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: tx/busy/done/drop=%b/%b/%b/%h required 1/0/0/00",
                     ifc.uart_tx, ifc.busy, ifc.frame_done, ifc.drop_count);
        end
        for (int k = 0; k < 400; k++) begin
            tick();
            if (ifc.frame_done !== 1'b0 || ifc.uart_tx !== 1'b1 || ifc.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_abandon: %0d bad cycles, required 0", bad); end
        set_random_inputs();
        f = model_from_inputs();
        ifc.trigger = 1'b1;
        fork
            sample_window(F + 10);
            begin tick(); ifc.trigger = 1'b0; end
        join
        checks++;
        if (wave_errs(f, 0) !== 0 || done_cnt !== 1 || done_at[0] !== F + 1) begin
            errors++;
            $display("FAIL mid_recover: %0d bad cycles, %0d pulses at %0d, required 0, 1 at %0d",
                     wave_errs(f, 0), done_cnt, done_at[0], F + 1);
        end
    endtask

    task automatic test_random_frames();
        logic [63:0] f;
        int chg;
        for (int n = 0; n < 4; n++) begin
            set_random_inputs();
            f = model_from_inputs();
            chg = int'($urandom_range(1, F - 1));
            ifc.trigger = 1'b1;
            fork
                sample_window(F + 5);
                begin
                    tick(); ifc.trigger = 1'b0;
                    repeat (chg) tick();
                    set_random_inputs();
                end
            join
            checks++;
            if (wave_errs(f, 0) !== 0 || busy_cnt !== F || done_cnt !== 1) begin
                errors++;
                $display("FAIL random_frame%0d: %0d bad cycles busy %0d done %0d, required 0/%0d/1",
                         n, wave_errs(f, 0), busy_cnt, done_cnt, F);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_coherence();
        test_drops();
        test_back_to_back();
        test_reset_mid();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
